transpose_buffer: RTL and testbench
===================================

Name: transpose_buffer

Overview:
- Intermediate transpose stage of the 2D DCT-II datapath, placed between the row-pass 1D DCT and the column-pass 1D DCT.
- Accepts one row-pass coefficient per cycle in row-major order for an NxN block (N = 4/8/16/32).
- Stores the whole block, then emits it in column-major order so the column pass receives transposed data.
- Single-buffered: a block is fully written before it is read. Both streaming sides use valid/ready handshakes.

Parameters:
WIDTH, 16, coefficient bit width on input and output.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
N  input  2  block size code: 2'b00=4, 2'b01=8, 2'b10=16, 2'b11=32. Sampled only on first accepted input sample of a block.
in_valid  input  1  upstream has a coefficient on in_data.
in_data  input  WIDTH  row-pass coefficient, signed, row-major order.
in_ready  output  1  buffer can accept a sample this cycle.
out_valid  output  1  out_data holds a valid transposed coefficient.
out_data  output  WIDTH  transposed coefficient, column-major order.
out_ready  input  1  downstream accepts out_data this cycle.
out_last  output  1  high with the final coefficient (row N-1, col N-1) of a block.
busy  output  1  high in FILL or DRAIN.
state  output  2  current state: 00=IDLE, 01=FILL, 10=DRAIN; 11 unused.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; in_ready=0 while reset is asserted, then 1 from the first cycle in IDLE.
  - out_valid=0, out_last=0, busy=0, out_data=0.
  - Row/column counters=0; latched size=4.
  - Memory contents undefined; they are never read before being written.
- Storage: 32x32 array of WIDTH-bit words, addressed [row][col]. Only the top-left NxN region is used.
- Input handshake: a sample is accepted when in_valid & in_ready on a rising edge.
- Output handshake: a sample is consumed when out_valid & out_ready on a rising edge.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an accepted sample: latch N into Nl, write mem[0][0], set wcol=1, go to FILL.
  - For N=4 the block does not complete on this first sample.
- FILL:
  - in_ready=1. Each accepted sample writes mem[wrow][wcol], then wcol increments.
  - When wcol reaches Nl-1, wcol wraps to 0 and wrow increments.
  - On accepting sample (Nl-1, Nl-1): go to DRAIN next cycle, with rrow=0, rcol=0.
  - in_valid=0 stalls with no state change.
  - The N input is ignored in FILL.
- DRAIN:
  - in_ready=0, out_valid=1.
  - out_data = mem[rrow][rcol], combinational from the registered counters.
  - On each consumed sample rrow increments. When rrow reaches Nl-1, rrow wraps to 0 and rcol increments.
  - Emission order: all rows of column 0, then column 1, and so on.
  - out_last = out_valid & (rrow==Nl-1) & (rcol==Nl-1).
  - Consuming the out_last sample returns to IDLE. in_ready=1 from the next cycle.
  - out_ready=0 holds out_data, counters and out_last stable.
- Latency: the first output is valid the cycle after the last input sample is accepted.
  - Minimum block period with no stalls: 2·N² cycles (N² fill plus N² drain, with no bubble between them).
- Back-to-back blocks: there is no overlap between blocks. Input for the next block is accepted only from IDLE.
- Counters: 5-bit wrow/wcol/rrow/rcol, compared against Nl-1. Bits above log2(Nl) stay 0.
- Data passes through unmodified: no rounding, no sign handling.
- Reset mid-operation: all control returns to IDLE immediately. The partial block is discarded and no out_last is produced.
- Illegal state encoding 11: next state is IDLE.

Test Plan:
1. N=2'b00, in_data=0..15 streamed back-to-back with out_ready=1.
   - Outputs must be 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15.
   - out_last must coincide with 15.
   - First out_valid must occur exactly 1 cycle after sample 15 is accepted.
   - state must return to 00 after the last output.
2. N=2'b11, in_data = row·32+col for all 1024 samples.
   - Output k must equal (k mod 32)·32 + (k div 32).
   - Exactly 1024 outputs.
   - in_ready must be 0 for the entire drain.
3. N=2'b01 with in_valid toggled every other cycle and out_ready=0 for 3 cycles in the middle of the drain.
   - Output sequence must equal the 8x8 transpose.
   - out_data must be held stable while out_ready=0.
   - No duplicated or dropped samples.
4. Start an 8x8 block (N=01), then drive N=2'b11 after sample 5.
   - The block must still complete after 64 inputs and 64 outputs.
   - The next block must latch N=32.
5. Assert reset=0 asynchronously, between clock edges, after 10 inputs of a 16x16 block.
   - busy, out_valid and state must go to 0 immediately.
   - A fresh 4x4 block afterwards must transpose correctly.
6. Two consecutive 4x4 blocks with in_valid held high.
   - in_ready must be 0 for exactly 16 cycles between the blocks.
   - Both output blocks must be correct.

Source files
------------

// File: rtl/transpose_buffer.sv
// Block transpose stage between the row and column DCT passes: an NxN block
// (N = 4/8/16/32) is written row-major and then read back column-major.
module transpose_buffer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       N,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic [1:0]       state
);

    // Handshakes: a word moves on a rising edge when valid & ready are both
    // high; ready never depends on valid on either side.
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_FILL  = 2'b01,
        S_DRAIN = 2'b10,
        S_BAD   = 2'b11
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] nl_q, nl_d;
    logic [4:0] wrow_q, wrow_d;
    logic [4:0] wcol_q, wcol_d;
    logic [4:0] rrow_q, rrow_d;
    logic [4:0] rcol_q, rcol_d;
    logic       en_q;

    logic [WIDTH-1:0] mem [0:31][0:31];

    logic [4:0] lim_w;
    logic [4:0] lim_r;
    logic       in_fire;
    logic       out_fire;

    function automatic logic [4:0] size_max(input logic [1:0] code);
        case (code)
            2'b00:   size_max = 5'd3;
            2'b01:   size_max = 5'd7;
            2'b10:   size_max = 5'd15;
            default: size_max = 5'd31;
        endcase
    endfunction

    // In IDLE the first sample of a block is sized by the live N input.
    assign lim_w = (state_q == S_IDLE) ? size_max(N) : size_max(nl_q);
    assign lim_r = size_max(nl_q);

    always_comb begin
        in_ready  = en_q && ((state_q == S_IDLE) || (state_q == S_FILL));
        out_valid = (state_q == S_DRAIN);
        out_data  = out_valid ? mem[rrow_q][rcol_q] : '0;
        out_last  = out_valid && (rrow_q == lim_r) && (rcol_q == lim_r);
        busy      = (state_q == S_FILL) || (state_q == S_DRAIN);
        state     = state_q;
    end

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        nl_d    = nl_q;
        wrow_d  = wrow_q;
        wcol_d  = wcol_q;
        rrow_d  = rrow_q;
        rcol_d  = rcol_q;
        case (state_q)
            S_IDLE: begin
                if (in_fire) begin
                    nl_d    = N;
                    wrow_d  = 5'd0;
                    wcol_d  = 5'd1;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (in_fire) begin
                    if (wcol_q == lim_w) begin
                        wcol_d = 5'd0;
                        if (wrow_q == lim_w) begin
                            wrow_d  = 5'd0;
                            rrow_d  = 5'd0;
                            rcol_d  = 5'd0;
                            state_d = S_DRAIN;
                        end else begin
                            wrow_d = wrow_q + 5'd1;
                        end
                    end else begin
                        wcol_d = wcol_q + 5'd1;
                    end
                end
            end
            S_DRAIN: begin
                // Row index runs fastest so columns leave one at a time.
                if (out_fire) begin
                    if (rrow_q == lim_r) begin
                        rrow_d = 5'd0;
                        if (rcol_q == lim_r) begin
                            rcol_d  = 5'd0;
                            state_d = S_IDLE;
                        end else begin
                            rcol_d = rcol_q + 5'd1;
                        end
                    end else begin
                        rrow_d = rrow_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                wrow_d  = 5'd0;
                wcol_d  = 5'd0;
                rrow_d  = 5'd0;
                rcol_d  = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            nl_q    <= 2'b00;
            wrow_q  <= 5'd0;
            wcol_q  <= 5'd0;
            rrow_q  <= 5'd0;
            rcol_q  <= 5'd0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            nl_q    <= nl_d;
            wrow_q  <= wrow_d;
            wcol_q  <= wcol_d;
            rrow_q  <= rrow_d;
            rcol_q  <= rcol_d;
            en_q    <= 1'b1;
        end
    end

    // Write counters sit at 0 in IDLE, so one address path covers every sample.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            mem[wrow_q][wcol_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_transpose_buffer.sv
// Self-checking bench for transpose_buffer: scenario tasks drive blocks while a
// collector pops transposed expectations from a scoreboard queue.
module tb_transpose_buffer;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   N;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;
    logic         out_last;
    logic         busy;
    logic [1:0]   state;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] stim[$];
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_acc_cyc;
    int first_val_cyc;
    int gap_zero;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    transpose_buffer #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .N        (N),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .out_last (out_last),
        .busy     (busy),
        .state    (state)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Appends one n x n block to the stimulus and its transpose to the scoreboard.
    task automatic add_block(input int n, input bit rnd);
        int off;
        off = stim.size();
        for (int k = 0; k < n * n; k++)
            stim.push_back(rnd ? 16'($urandom_range(0, 65535)) : 16'(k));
        for (int c = 0; c < n; c++)
            for (int r = 0; r < n; r++)
                exp_q.push_back(stim[off + r * n + c]);
    endtask

    task automatic drive(input logic [1:0] code, input bit toggle, input int n_switch_at);
        int idx;
        int t;
        bit ph;
        idx = 0;
        t = 0;
        ph = 1'b1;
        gap_zero = 0;
        while (idx < stim.size() && t < stim.size() * 4 + 3000) begin
            @(negedge clk);
            t++;
            in_valid = toggle ? ph : 1'b1;
            ph = ~ph;
            in_data = stim[idx];
            N = (n_switch_at >= 0 && idx >= n_switch_at) ? 2'b11 : code;
            if (!in_ready) gap_zero++;
            if (in_valid && in_ready) begin
                last_acc_cyc = cyc;
                idx++;
            end
        end
        if (idx < stim.size()) begin
            n_checks++;
            n_fail++;
            $display("FAIL drive_timeout: accepted %0d of %0d samples", idx, stim.size());
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic collect(input int total, input int blk, input int stall_after, input bit chk_ready);
        int got;
        int t;
        int stalln;
        logic [W-1:0] held;
        logic [W-1:0] e;
        got = 0;
        t = 0;
        stalln = 0;
        held = '0;
        first_val_cyc = -1;
        out_ready = 1'b1;
        while (got < total && t < total * 4 + 6000) begin
            @(negedge clk);
            t++;
            if (out_valid && first_val_cyc < 0) first_val_cyc = cyc;
            if (out_valid && chk_ready) begin
                n_checks++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL drain_in_ready: got %b want 0 at output %0d", in_ready, got);
                end
            end
            if (out_valid && stall_after >= 0 && got == stall_after && stalln < 3) begin
                if (stalln > 0) begin
                    n_checks++;
                    if (out_data !== held) begin
                        n_fail++;
                        $display("FAIL stall_hold: got %h want %h", out_data, held);
                    end
                end else begin
                    held = out_data;
                end
                out_ready = 1'b0;
                stalln++;
            end else begin
                out_ready = 1'b1;
                if (out_valid) begin
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                    n_checks++;
                    if (out_data !== e) begin
                        n_fail++;
                        $display("FAIL out_data[%0d]: got %h want %h", got, out_data, e);
                    end
                    n_checks++;
                    if (out_last !== ((got % blk) == blk - 1)) begin
                        n_fail++;
                        $display("FAIL out_last[%0d]: got %b want %b", got, out_last, (got % blk) == blk - 1);
                    end
                    got++;
                end
            end
        end
        n_checks++;
        if (got != total) begin
            n_fail++;
            $display("FAIL collect_count: got %0d outputs want %0d", got, total);
        end
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        n_checks++;
        if (state !== 2'b00 || busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_idle: state=%b busy=%b out_valid=%b in_ready=%b want 00 0 0 1",
                     tag, state, busy, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        N = 2'b00;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        #1;
        n_checks++;
        if (state !== 2'b00 || busy !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 ||
            out_data !== '0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: state=%b busy=%b ov=%b ol=%b od=%h ir=%b want all 0",
                     state, busy, out_valid, out_last, out_data, in_ready);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        check_idle("reset_release");
    endtask

    task automatic test_4x4();
        stim.delete();
        add_block(4, 1'b0);
        fork
            drive(2'b00, 1'b0, -1);
            collect(16, 16, -1, 1'b1);
        join
        n_checks++;
        if (first_val_cyc != last_acc_cyc + 1) begin
            n_fail++;
            $display("FAIL latency: first valid cycle %0d want %0d", first_val_cyc, last_acc_cyc + 1);
        end
        check_idle("t1");
    endtask

    task automatic test_32x32();
        stim.delete();
        add_block(32, 1'b0);
        fork
            drive(2'b11, 1'b0, -1);
            collect(1024, 1024, -1, 1'b1);
        join
        check_idle("t2");
    endtask

    task automatic test_stalls();
        stim.delete();
        add_block(8, 1'b1);
        fork
            drive(2'b01, 1'b1, -1);
            collect(64, 64, 30, 1'b1);
        join
        check_idle("t3");
    endtask

    task automatic test_n_ignored();
        stim.delete();
        add_block(8, 1'b1);
        fork
            drive(2'b01, 1'b0, 5);
            collect(64, 64, -1, 1'b0);
        join
        check_idle("t4a");
        stim.delete();
        add_block(32, 1'b1);
        fork
            drive(2'b11, 1'b0, -1);
            collect(1024, 1024, -1, 1'b0);
        join
        check_idle("t4b");
    endtask

    task automatic test_mid_reset();
        stim.delete();
        for (int k = 0; k < 10; k++) stim.push_back(16'($urandom_range(0, 65535)));
        drive(2'b10, 1'b0, -1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || state !== 2'b00 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: busy=%b out_valid=%b state=%b in_ready=%b want 0 0 00 0",
                     busy, out_valid, state, in_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        stim.delete();
        add_block(4, 1'b1);
        fork
            drive(2'b00, 1'b0, -1);
            collect(16, 16, -1, 1'b1);
        join
        check_idle("t5");
    endtask

    task automatic test_back_to_back();
        stim.delete();
        add_block(4, 1'b1);
        add_block(4, 1'b1);
        fork
            drive(2'b00, 1'b0, -1);
            collect(32, 16, -1, 1'b1);
        join
        n_checks++;
        if (gap_zero != 16) begin
            n_fail++;
            $display("FAIL b2b_gap: in_ready low for %0d cycles want 16", gap_zero);
        end
        check_idle("t6");
    endtask

    initial begin
        test_reset();
        test_4x4();
        test_32x32();
        test_stalls();
        test_n_ignored();
        test_mid_reset();
        test_back_to_back();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: %0d entries left want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
